// File: rtl/branch_resolve_unit_if.sv
// Bus between the pipeline and branch_resolve_unit: fetch predictions in, EX resolutions in,
// predictor training and front-end redirect out. Stats ports exist only with BRU_STATS_EN.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            pred_valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
    logic [XLEN-1:0] pred_target;
    logic            res_valid;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            fetch_stall;
    logic            update_valid;
    logic            update_taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            underflow_err;
`ifdef BRU_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    modport master (
        output pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken, res_target,
        input  fetch_stall, update_valid, update_taken, mispredict, redirect_pc, underflow_err,
        input  stat_branches, stat_mispredicts
    );
    modport slave (
        input  pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken, res_target,
        output fetch_stall, update_valid, update_taken, mispredict, redirect_pc, underflow_err,
        output stat_branches, stat_mispredicts
    );
`else
    modport master (
        output pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken, res_target,
        input  fetch_stall, update_valid, update_taken, mispredict, redirect_pc, underflow_err
    );
    modport slave (
        input  pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken, res_target,
        output fetch_stall, update_valid, update_taken, mispredict, redirect_pc, underflow_err
    );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves in-flight branch predictions in order, trains the predictor and flushes on mispredict.
// Optional BRU_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_resolve_unit_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            update_valid_q, update_valid_d;
    logic            update_taken_q, update_taken_d;
    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            underflow_q, underflow_d;

    logic            full, empty, do_pop, do_push, wrong;
    entry_t          head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        update_valid_d = 1'b0;
        update_taken_d = 1'b0;
        mispredict_d   = 1'b0;
        redirect_pc_d  = redirect_pc_q;
        underflow_d    = underflow_q | (bus.res_valid & empty);

        do_pop  = bus.res_valid & ~empty;
        wrong   = do_pop & ((bus.res_taken != head.taken) ||
                            (bus.res_taken && head.taken && (bus.res_target != head.target)));
        // A push racing a mispredict is wrong-path; a pop frees a slot even when full.
        do_push = bus.pred_valid & (~full | do_pop) & ~wrong;

        if (do_pop) begin
            update_valid_d = 1'b1;
            update_taken_d = bus.res_taken;
        end

        if (do_push) begin
            mem_d[wr_ptr_q] = '{taken: bus.pred_taken, pc: bus.pred_pc, target: bus.pred_target};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (wrong) begin
            mispredict_d  = 1'b1;
            redirect_pc_d = bus.res_taken ? bus.res_target : head.pc + XLEN'(4);
            rd_ptr_d      = wr_ptr_q;
            count_d       = '0;
        end else begin
            if (do_pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)
                count_d = count_q + (AW+1)'(1);
            else if (do_pop && !do_push)
                count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            update_valid_q <= 1'b0;
            update_taken_q <= 1'b0;
            mispredict_q   <= 1'b0;
            redirect_pc_q  <= '0;
            underflow_q    <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            update_valid_q <= update_valid_d;
            update_taken_q <= update_taken_d;
            mispredict_q   <= mispredict_d;
            redirect_pc_q  <= redirect_pc_d;
            underflow_q    <= underflow_d;
        end
    end

    assign bus.fetch_stall   = full;
    assign bus.update_valid  = update_valid_q;
    assign bus.update_taken  = update_taken_q;
    assign bus.mispredict    = mispredict_q;
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.underflow_err = underflow_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Counters land on the same edge as update_valid, saturating at all-ones.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (do_pop && stat_br_q != '1)
            stat_br_d = stat_br_q + 32'd1;
        if (wrong && stat_mp_q != '1)
            stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against a queue model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    branch_resolve_unit_if #(.XLEN(XLEN)) bif ();

    branch_resolve_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } pred_t;

    pred_t       q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp_uv, exp_ut, exp_mis, exp_uf;
    logic [31:0] exp_redir;
    logic [31:0] exp_sb, exp_sm;

    logic        r_pv, r_pt, r_rv, r_rt;
    logic [31:0] r_ppc, r_ptg, r_rtg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_uv"}, 64'(bif.update_valid), 64'(exp_uv));
        if (exp_uv)
            check({tag, "_ut"}, 64'(bif.update_taken), 64'(exp_ut));
        check({tag, "_mis"}, 64'(bif.mispredict), 64'(exp_mis));
        check({tag, "_redir"}, 64'(bif.redirect_pc), 64'(exp_redir));
        check({tag, "_uf"}, 64'(bif.underflow_err), 64'(exp_uf));
        check({tag, "_stall"}, 64'(bif.fetch_stall), 64'(q.size() == DEPTH));
`ifdef BRU_STATS_EN
        check({tag, "_sb"}, 64'(bif.stat_branches), 64'(exp_sb));
        check({tag, "_sm"}, 64'(bif.stat_mispredicts), 64'(exp_sm));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        exp_uv = 0; exp_ut = 0; exp_mis = 0; exp_uf = 0;
        exp_redir = '0; exp_sb = '0; exp_sm = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                        input logic rv, input logic rt, input logic [31:0] rtg, input string tag);
        pred_t h;
        logic  wrong;
        bif.pred_valid = pv; bif.pred_taken = pt; bif.pred_pc = ppc; bif.pred_target = ptg;
        bif.res_valid  = rv; bif.res_taken  = rt; bif.res_target = rtg;
        exp_uv = 0; exp_mis = 0; wrong = 0;
        if (rv) begin
            if (q.size() == 0) begin
                exp_uf = 1;
            end else begin
                h = q.pop_front();
                exp_uv = 1;
                exp_ut = rt;
                if (exp_sb != 32'hFFFF_FFFF) exp_sb++;
                wrong = (h.taken != rt) || (rt && rtg != h.target);
                if (wrong) begin
                    exp_mis   = 1;
                    exp_redir = rt ? rtg : h.pc + 32'd4;
                    if (exp_sm != 32'hFFFF_FFFF) exp_sm++;
                    q.delete();
                end
            end
        end
        if (pv && !wrong && q.size() < DEPTH)
            q.push_back('{pt, ppc, ptg});
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, tag);
    endtask

    initial begin
        bif.pred_valid = 0; bif.pred_taken = 0; bif.pred_pc = '0; bif.pred_target = '0;
        bif.res_valid  = 0; bif.res_taken  = 0; bif.res_target = '0;
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compare_all("reset");
        reset = 1'b0;

        // Correct taken prediction.
        step(1, 1, 32'h100, 32'h200, 0, 0, 32'h0, "tp1_push");
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h200, "tp1_res");
        check("tp1_uv_const", 64'(bif.update_valid), 64'd1);
        check("tp1_ut_const", 64'(bif.update_taken), 64'd1);
        check("tp1_mis_const", 64'(bif.mispredict), 64'd0);
        idle("tp1_idle");
        check("tp1_pulse", 64'(bif.update_valid), 64'd0);

        // Predicted not-taken, actually taken.
        step(1, 0, 32'h104, 32'h500, 0, 0, 32'h0, "tp2_push");
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h300, "tp2_res");
        check("tp2_mis_const", 64'(bif.mispredict), 64'd1);
        check("tp2_redir_const", 64'(bif.redirect_pc), 64'h300);
        idle("tp2_idle");

        // Predicted taken, actually not-taken with younger entries flushed.
        step(1, 1, 32'h110, 32'h400, 0, 0, 32'h0, "tp3_p0");
        step(1, 0, 32'h120, 32'h0,   0, 0, 32'h0, "tp3_p1");
        step(1, 1, 32'h130, 32'h600, 0, 0, 32'h0, "tp3_p2");
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0, "tp3_res");
        check("tp3_redir_const", 64'(bif.redirect_pc), 64'h114);
        idle("tp3_idle");
        check("tp3_redir_hold", 64'(bif.redirect_pc), 64'h114);
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h0, "tp3_under");
        check("tp3_uf_const", 64'(bif.underflow_err), 64'd1);
        check("tp3_uv_empty", 64'(bif.update_valid), 64'd0);

        // Fill, drop when full, push+pop while full, drain in order.
        for (int i = 0; i < DEPTH; i++)
            step(1, i[0], 32'h200 + 32'(4 * i), 32'h800 + 32'(16 * i), 0, 0, 32'h0, "tp4_fill");
        check("tp4_stall_full", 64'(bif.fetch_stall), 64'd1);
        step(1, 1, 32'h2F0, 32'h9F0, 0, 0, 32'h0, "tp4_drop");
        step(1, 1, 32'h210, 32'h900, 1, q[0].taken, q[0].target, "tp4_pushpop");
        check("tp4_stall_kept", 64'(bif.fetch_stall), 64'd1);
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 32'h0, 32'h0, 1, q[0].taken, q[0].target, "tp4_drain");
        check("tp4_stall_empty", 64'(bif.fetch_stall), 64'd0);
        step(1, 0, 32'h300, 32'h0, 0, 0, 32'h0, "tp4_wrap0");
        for (int i = 1; i <= 10; i++)
            step(1, i[1], 32'h300 + 32'(4 * i), 32'hA00 + 32'(16 * i), 1, q[0].taken, q[0].target, "tp4_wrap");
        step(0, 0, 32'h0, 32'h0, 1, q[0].taken, q[0].target, "tp4_last");

        // Push racing a mispredicting resolve is discarded.
        step(1, 1, 32'h400, 32'h480, 0, 0, 32'h0, "tp5_p0");
        step(1, 1, 32'h404, 32'h4C0, 0, 0, 32'h0, "tp5_p1");
        step(1, 0, 32'h408, 32'h0, 1, 0, 32'h0, "tp5_race");
        check("tp5_mis_const", 64'(bif.mispredict), 64'd1);
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0, "tp5_after");
        check("tp5_empty_uv", 64'(bif.update_valid), 64'd0);

        // Reset while entries and a strobe are live.
        step(1, 1, 32'h500, 32'h580, 0, 0, 32'h0, "tp6_p0");
        step(1, 0, 32'h504, 32'h0,   0, 0, 32'h0, "tp6_p1");
        step(1, 1, 32'h508, 32'h5C0, 1, 1, 32'h580, "tp6_res");
        bif.pred_valid = 0; bif.res_valid = 0;
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all("tp6_rst_now");
        @(negedge clk);
        compare_all("tp6_rst_hold");
        reset = 1'b0;
        idle("tp6_idle");

        for (int i = 0; i < 400; i++) begin
            r_pv  = ($urandom_range(0, 99) < 55);
            r_pt  = 1'($urandom_range(0, 1));
            r_ppc = $urandom & 32'hFFFF_FFFC;
            r_ptg = $urandom & 32'hFFFF_FFFC;
            r_rv  = ($urandom_range(0, 99) < 50);
            if (q.size() != 0 && $urandom_range(0, 99) < 75) begin
                r_rt  = q[0].taken;
                r_rtg = q[0].target;
            end else begin
                r_rt  = 1'($urandom_range(0, 1));
                r_rtg = (q.size() != 0 && $urandom_range(0, 1) == 1) ? q[0].target
                                                                     : ($urandom & 32'hFFFF_FFFC);
            end
            step(r_pv, r_pt, r_ppc, r_ptg, r_rv, r_rt, r_rtg, "rnd");
        end
        idle("end_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-end counterpart of the fetch-stage 2-bit branch predictor.
- Tracks in-flight predictions issued at fetch in a small in-order queue, and compares each against the actual outcome when the branch resolves in EX.
- Produces the one-cycle update strobe and outcome that train the predictor, plus the mispredict flush and redirect PC for the pipeline front end.

Parameters:
- DEPTH, 4, number of in-flight predicted branches held; power of 2, at least 2.
- XLEN, 32, PC and target width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- pred_valid  in  1  fetch issued a branch prediction this cycle.
- pred_taken  in  1  predicted direction.
- pred_pc  in  XLEN  PC of the predicted branch.
- pred_target  in  XLEN  target used by fetch if predicted taken.
- res_valid  in  1  EX resolved the oldest in-flight branch this cycle.
- res_taken  in  1  actual direction.
- res_target  in  XLEN  actual taken target.
- fetch_stall  out  1  queue full; fetch must not issue pred_valid.
- update_valid  out  1  one-cycle strobe to the predictor.
- update_taken  out  1  actual outcome, drives predictor branch_taken.
- mispredict  out  1  one-cycle flush pulse.
- redirect_pc  out  XLEN  correct next PC; valid while mispredict=1.
- underflow_err  out  1  sticky; res_valid seen with queue empty.

Behaviour:
- Reset (async, immediate): queue empty, rd_ptr=wr_ptr=0, count=0. update_valid=0, update_taken=0, mispredict=0, redirect_pc=0, underflow_err=0. fetch_stall=0.
- Queue:
  - Circular buffer of {taken, pc, target}.
  - Pointers of log2(DEPTH) bits wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - fetch_stall = (count==DEPTH), combinational.
- Push: on pred_valid && !full, write at wr_ptr, wr_ptr+1. pred_valid while full is ignored and the entry is dropped.
- Resolve: on res_valid && count!=0:
  - Pop head.
  - Next cycle: update_valid=1, update_taken=res_taken (latency 1, registered).
  - Mispredict if res_taken != head.taken, or if both taken and res_target != head.target.
  - On mispredict, next cycle: mispredict=1 and redirect_pc = res_taken ? res_target : head.pc+4 (XLEN wrap). All remaining queue entries are discarded (wrong path): count=0, rd_ptr=wr_ptr.
- Correct prediction: mispredict=0, redirect_pc holds its last value.
- Push and resolve in the same cycle, no mispredict: both occur, count unchanged. Push is allowed when full only if a pop happens in the same cycle.
- Push and resolve in the same cycle, mispredict: the push is wrong-path and is discarded; queue ends empty.
- Cycle after mispredict: front end is flushed. Any pred_valid in that cycle is accepted normally (correct-path fetch).
- res_valid with queue empty: no update, no mispredict; underflow_err set and held until reset.
- Outputs are pulses, never held longer than one cycle per resolve. Back-to-back resolves produce back-to-back strobes.
- Reset mid-operation: all in-flight entries are lost and no strobe is emitted.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined: adds outputs stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on every valid resolve.
  - stat_mispredicts increments on every mispredict.
  - Both saturate at 0xFFFFFFFF and clear on reset.
  - Counters update in the same cycle as update_valid.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Push {taken=1, pc=0x100, tgt=0x200}, then resolve taken, target 0x200 -> one cycle later update_valid=1, update_taken=1, mispredict=0.
- Push {taken=0, pc=0x104}, then resolve taken, target 0x300 -> mispredict=1, redirect_pc=0x300, update_taken=0→1 strobe.
- Push three entries, first predicted taken, then resolve the first as not-taken -> mispredict=1, redirect_pc=head.pc+4, count=0 afterwards. A later res_valid sets underflow_err=1.
- Push DEPTH=4 entries -> fetch_stall=1 and a 5th push is dropped. Same-cycle push+correct resolve keeps count=4. Pointers wrap over 10 iterations with results in order.
- Same-cycle push with a mispredicting resolve -> push is discarded, queue empty. Assert reset mid-queue -> all outputs 0 immediately, no strobe.
- With BRU_STATS_EN: 5 resolves including 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Preload 0xFFFFFFFF via forced reach -> stays 0xFFFFFFFF.
